// File: rtl/transchroma_pkg.sv
// Shared constants and types for the Cb/Cr nonlinear chroma transform pipe.
// Fixed-point values are signed Q.FRAC; the channel tag travels with each pixel.
package transchroma_pkg;

   localparam int DEF_FP_W  = 24;
   localparam int DEF_FRAC  = 10;
   localparam int DEF_OUT_W = 20;

   // Luma band in which chroma is passed through untouched.
   localparam int DEF_K_L = 125;
   localparam int DEF_K_H = 188;

   typedef enum logic {
      CH_CB = 1'b0,
      CH_CR = 1'b1
   } chan_e;

   function automatic int to_fp(input int v);
      return v <<< DEF_FRAC;
   endfunction

   localparam int DEF_MEAN_KH_CB = to_fp(108);
   localparam int DEF_MEAN_KH_CR = to_fp(154);

   // Per-pixel side-band carried down the pipe alongside the arithmetic.
   typedef struct packed {
      chan_e      sel;
      logic       pass;
      logic [7:0] c;
   } ctl_t;

endpackage

// File: rtl/transchroma_pipe_fp_mult_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// then either truncation (SAT = 0) or clamping (SAT = 1) back to W bits.
module fp_mult_sat #(
   parameter int W    = 24,
   parameter int FRAC = 10,
   parameter bit SAT  = 1'b0
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] p
);

   localparam int PW = 2 * W;
   localparam logic signed [W-1:0] P_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] P_MIN = {1'b1, {(W-1){1'b0}}};

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic                 fits;

   // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
   always_comb begin
      prod    = PW'(a) * PW'(b);
      shifted = prod >>> FRAC;
      fits    = (&shifted[PW-1:W-1]) || !(|shifted[PW-1:W-1]);
      p       = shifted[W-1:0];
      if (SAT && !fits) begin
         p = shifted[PW-1] ? P_MIN : P_MAX;
      end
   end

endmodule

// File: rtl/transchroma_pipe.sv
// Six-register chroma transform pipe (S0..S5) shared by Cb and Cr, with a
// global stall, external mean/width LUT port, bypass band and output clamp.
module transchroma_pipe
   import transchroma_pkg::*;
#(
   parameter int FP_W       = DEF_FP_W,
   parameter int FRAC       = DEF_FRAC,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int K_L        = DEF_K_L,
   parameter int K_H        = DEF_K_H,
   parameter int MEAN_KH_CB = DEF_MEAN_KH_CB,
   parameter int MEAN_KH_CR = DEF_MEAN_KH_CR
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_y,
   input  logic [7:0]             in_c,
   input  logic                   in_sel,
   input  logic                   cfg_bypass,
   output logic [7:0]             lut_y,
   output logic                   lut_sel,
   input  logic signed [FP_W-1:0] lut_mean,
   input  logic signed [FP_W-1:0] lut_width,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_sel
);

   localparam logic [7:0]             K_L8    = 8'(K_L);
   localparam logic [7:0]             K_H8    = 8'(K_H);
   localparam logic signed [FP_W-1:0] CTR_CB  = FP_W'(MEAN_KH_CB);
   localparam logic signed [FP_W-1:0] CTR_CR  = FP_W'(MEAN_KH_CR);
   localparam logic signed [FP_W-1:0] R_MAX   = FP_W'(255 << FRAC);
   localparam logic [OUT_W-1:0]       OUT_MAX = OUT_W'(255 << FRAC);

   function automatic logic signed [FP_W-1:0] chroma_fp(input logic [7:0] c);
      logic [FP_W-1:0] v;
      v = '0;
      v[FRAC +: 8] = c;
      return signed'(v);
   endfunction

   logic                   en;
   logic [4:0]             vld;
   logic [7:0]             y0;
   ctl_t                   s0, s1, s2, s3, s4;
   logic                   in_band0;
   logic signed [FP_W-1:0] mean1, width1;
   logic signed [FP_W-1:0] d2, width2;
   logic signed [FP_W-1:0] prod3, p3;
   logic signed [FP_W-1:0] a4;
   logic signed [FP_W-1:0] r5;
   logic [OUT_W-1:0]       sat5;

   assign en       = !out_valid || out_ready;
   assign in_ready = en && rst_n;
   assign lut_y    = y0;
   assign lut_sel  = s0.sel;
   assign in_band0 = (y0 >= K_L8) && (y0 <= K_H8);

   fp_mult_sat #(
      .W    (FP_W),
      .FRAC (FRAC),
      .SAT  (1'b0)
   ) u_mult (
      .a (d2),
      .b (width2),
      .p (prod3)
   );

   always_comb begin
      r5   = s4.pass ? chroma_fp(s4.c) : a4;
      sat5 = r5[OUT_W-1:0];
      if (r5 < 0) begin
         sat5 = '0;
      end else if (r5 > R_MAX) begin
         sat5 = OUT_MAX;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 1'b0;
      end else if (en) begin
         vld       <= {vld[3:0], in_valid && in_ready};
         out_valid <= vld[4];
         out_data  <= sat5;
         out_sel   <= s4.sel;
      end
   end

   // NOTE: datapath registers carry no reset; the valid chain alone decides what reaches the output.
   always_ff @(posedge clk) begin
      if (en) begin
         // S0 holds cfg_bypass in the pass field until the band test in S1.
         y0     <= in_y;
         s0     <= '{sel: chan_e'(in_sel), pass: cfg_bypass, c: in_c};

         s1     <= '{sel: s0.sel, pass: s0.pass || in_band0, c: s0.c};
         mean1  <= lut_mean;
         width1 <= lut_width;

         s2     <= s1;
         d2     <= chroma_fp(s1.c) - mean1;
         width2 <= width1;

         s3     <= s2;
         p3     <= prod3;

         s4     <= s3;
         a4     <= p3 + ((s3.sel == CH_CR) ? CTR_CR : CTR_CB);
      end
   end

endmodule
